// File: rtl/csa_resolver.sv
// csa_resolver: converts a carry-save pair (ps, pc) into one binary result
// {carry, s} = ps + (pc << 1). The carry-propagate add is done CHUNK bits per
// cycle over NCH cycles, with valid/ready handshakes on both sides.
module csa_resolver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ps,
  input  logic [WIDTH-1:0] pc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   s,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned EW  = WIDTH + 2;
  localparam int unsigned NCH = (EW + CHUNK - 1) / CHUNK;
  localparam int unsigned PW  = NCH * CHUNK;
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   b_q, b_d;
  logic [PW-1:0]   res_q, res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   sum_ch;

  // Select the operand chunk addressed by idx and add it with the carry flop.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (idx_q == IW'(c)) begin
        a_ch = a_q[c*CHUNK +: CHUNK];
        b_ch = b_q[c*CHUNK +: CHUNK];
      end
    end
    sum_ch = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, cy_q};
  end

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = PW'(ps);
          b_d     = PW'({pc, 1'b0});
          res_d   = '0;
          idx_d   = '0;
          cy_d    = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int unsigned c = 0; c < NCH; c++) begin
          if (idx_q == IW'(c)) begin
            res_d[c*CHUNK +: CHUNK] = sum_ch[CHUNK-1:0];
          end
        end
        cy_d  = sum_ch[CHUNK];
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NCH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      cy_q        <= cy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = res_q[WIDTH:0];
  assign carry     = res_q[EW-1];

endmodule
